// File: rtl/maze_round_controller.sv
// Maze round controller: sequences one game of the maze (idle, maze
// generation, timed play, game over), runs the one-second countdown,
// awards bonus time and score for each solved maze, keeps the best
// score, and gates the player's direction so it only reaches the maze
// during play.
module maze_round_controller #(
  parameter int TICKS_PER_SECOND = 50000000,
  parameter int ROUND_SECONDS    = 60,
  parameter int BONUS_SECONDS    = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       gen_end,
  input  logic [7:0] mazes_complete,
  input  logic [3:0] direction_in,
  output logic       game_reset,
  output logic       timer_end,
  output logic [3:0] direction_out,
  output logic [7:0] time_left,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [1:0] state
);

  // A single-tick second still needs a one-bit prescaler to hold its zero.
  localparam int            PRE_W      = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SECOND - 1);
  localparam logic [7:0]    ROUND_INIT = 8'(ROUND_SECONDS);
  localparam logic [9:0]    BONUS_ADD  = 10'(BONUS_SECONDS);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    GENERATING = 2'b01,
    PLAYING    = 2'b10,
    GAME_OVER  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] prescaler_q, prescaler_d;
  logic [7:0]       timeLeft_q, timeLeft_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       highScore_q, highScore_d;
  logic [7:0]       snapshot_q, snapshot_d;
  logic [3:0]       direction_q, direction_d;
  logic             start_q;

  logic             startEdge;
  logic             secondTick;
  logic             completion;
  logic [9:0]       bonusSum;

  assign startEdge  = start & ~start_q;
  assign secondTick = (prescaler_q == PRE_MAX);
  assign completion = (mazes_complete != snapshot_q);

  // Next-state and datapath decisions for every phase of the game.
  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    timeLeft_d  = timeLeft_q;
    score_d     = score_q;
    highScore_d = highScore_q;
    snapshot_d  = mazes_complete;
    direction_d = 4'b0000;
    // A tick landing on the same cycle as a completion still costs its second.
    bonusSum    = {2'b00, timeLeft_q} + BONUS_ADD - {9'd0, secondTick};

    case (state_q)
      IDLE, GAME_OVER: begin
        if (startEdge) begin
          state_d     = GENERATING;
          timeLeft_d  = ROUND_INIT;
          score_d     = 8'd0;
          prescaler_d = '0;
        end
      end

      GENERATING: begin
        if (gen_end) begin
          state_d = PLAYING;
        end
      end

      PLAYING: begin
        direction_d = direction_in;
        snapshot_d  = snapshot_q;
        prescaler_d = secondTick ? '0 : prescaler_q + PRE_W'(1);
        if (completion) begin
          snapshot_d = mazes_complete;
          score_d    = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
          timeLeft_d = (bonusSum > 10'd255) ? 8'hFF : bonusSum[7:0];
          state_d    = (timeLeft_d == 8'd0) ? GAME_OVER : GENERATING;
        end else if (secondTick) begin
          timeLeft_d = timeLeft_q - 8'd1;
          if (timeLeft_q == 8'd1) begin
            state_d = GAME_OVER;
          end else if (!gen_end) begin
            state_d = GENERATING;
          end
        end else if (!gen_end) begin
          state_d = GENERATING;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != GAME_OVER) && (state_d == GAME_OVER) && (score_d > highScore_q)) begin
      highScore_d = score_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      timeLeft_q  <= ROUND_INIT;
      score_q     <= 8'd0;
      highScore_q <= 8'd0;
      snapshot_q  <= 8'd0;
      direction_q <= 4'b0000;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      timeLeft_q  <= timeLeft_d;
      score_q     <= score_d;
      highScore_q <= highScore_d;
      snapshot_q  <= snapshot_d;
      direction_q <= direction_d;
      start_q     <= start;
    end
  end

  assign game_reset    = (state_q == IDLE) || (state_q == GAME_OVER);
  assign timer_end     = (state_q != PLAYING);
  assign direction_out = direction_q;
  assign time_left     = timeLeft_q;
  assign score         = score_q;
  assign high_score    = highScore_q;
  assign state         = state_q;

endmodule

// File: doc/maze_round_controller.md
MAZE_ROUND_CONTROLLER -- requirements
Module: maze_round_controller

Interface
REQ-001 Parameter TICKS_PER_SECOND, default 50000000: clock cycles per timer second.
REQ-002 Parameter ROUND_SECONDS, default 60: starting time per game (1..255).
REQ-003 Parameter BONUS_SECONDS, default 5: seconds added per maze solved (0..255).
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  player start button, level; already synchronous to clock.
REQ-007 gen_end  in  1  from Maze_Game: maze generation finished, play allowed.
REQ-008 mazes_complete  in  8  from Maze_Game: count of mazes solved since game reset.
REQ-009 direction_in  in  4  raw player direction (one-hot up/down/right/left, 0000 = none).
REQ-010 game_reset  out  1  drives Maze_Game reset.
REQ-011 timer_end  out  1  drives Maze_Game timer_end (freezes player).
REQ-012 direction_out  out  4  gated direction to Maze_Game player_direction.
REQ-013 time_left  out  8  remaining seconds.
REQ-014 score  out  8  mazes solved this game.
REQ-015 high_score  out  8  best score since reset.
REQ-016 state  out  2  current state: IDLE=00, GENERATING=01, PLAYING=10, GAME_OVER=11.

Function
REQ-017 start_edge = start & ~start_q, with start_q registered every cycle; only start_edge acts.
REQ-018 IDLE/GAME_OVER: game_reset=1, timer_end=1. On start_edge: next state GENERATING, time_left=ROUND_SECONDS, score=0, prescaler=0.
REQ-019 GENERATING: game_reset=0, timer_end=1, prescaler and time_left frozen. When gen_end=1: next state PLAYING.
REQ-020 PLAYING: game_reset=0, timer_end=0. Prescaler counts 0..TICKS_PER_SECOND-1 and wraps to 0; a wrap is one "second tick".
REQ-021 On a second tick, time_left decrements by 1. If time_left was 1, time_left becomes 0 and next state is GAME_OVER.
REQ-022 snapshot register: loads mazes_complete every cycle outside PLAYING. In PLAYING, completion = (mazes_complete != snapshot). On completion, snapshot reloads.
REQ-023 On completion: score += 1, saturating at 255; time_left += BONUS_SECONDS, saturating at 255; next state GENERATING.
REQ-024 Simultaneous completion and second tick: time_left = min(255, time_left - 1 + BONUS_SECONDS); completion wins and next state is GENERATING, even if time_left was 1. If the result is 0 (BONUS_SECONDS=0), next state is GAME_OVER.
REQ-025 gen_end falling to 0 in PLAYING without completion: next state GENERATING, time_left unchanged.
REQ-026 On the cycle GAME_OVER is entered: high_score = max(high_score, final score).
REQ-027 direction_out is registered: direction_in when state is PLAYING, else 0000; latency one cycle.
REQ-028 start_edge outside IDLE/GAME_OVER is ignored.
REQ-029 All arithmetic is unsigned 8-bit with explicit saturation; the prescaler width is ceil(log2(TICKS_PER_SECOND)).

Reset
REQ-030 reset=1 sampled on a clock edge gives: state=IDLE, game_reset=1, timer_end=1, direction_out=0000, time_left=ROUND_SECONDS, score=0, high_score=0, prescaler=0, start_q=0, snapshot=0.
REQ-031 Reset mid-game overrides every transition and clears high_score.

Verification (TICKS_PER_SECOND=4, ROUND_SECONDS=3, BONUS_SECONDS=2)
REQ-032 Reset, then start pulse -> state 00->01, game_reset 1->0, time_left=3, timer_end=1 until gen_end=1, then state=10, timer_end=0.
REQ-033 Hold gen_end=1, no completion -> time_left 3,2,1,0 at 4-cycle intervals; state=11, timer_end=1, game_reset=1, high_score=0.
REQ-034 In PLAYING with time_left=3, mazes_complete 0->1 -> score=1, time_left=5, state=01; direction_in=0100 gives direction_out=0000 until PLAYING resumes, then 0100 one cycle later.
REQ-035 mazes_complete increments on the same cycle as a tick with time_left=1 -> time_left=2, state=01, no GAME_OVER.
REQ-036 Game ends with score=2, then start held high for 10 cycles -> exactly one restart, score=0, high_score=2. A second game ending with score=1 leaves high_score=2.
REQ-037 reset asserted during PLAYING -> all outputs take REQ-030 values on the next edge.
